// File: rtl/sdram_req_queue.sv
// Request FIFO in front of a single-outstanding SDRAM controller; an accepted request issues 1 cycle later, and a completion or timeout yields one response.
// Upstream is stalled on a full queue; nothing is popped while a response is held for downstream.
module sdram_req_queue_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_dat,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full   = (count_q == CW'(DEPTH));
  assign count  = count_q;
  assign rd_dat = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth lets the pointers wrap by overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_dat;
  end
endmodule

module sdram_req_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [24:0]             req_addr,
  input  logic [1:0]              req_oplen,
  input  logic [31:0]             req_wdata,
  input  logic                    req_rw,
  output logic                    ctrl_enable,
  output logic [24:0]             ctrl_addr,
  output logic [1:0]              ctrl_oplen,
  output logic [31:0]             ctrl_wdata,
  output logic                    ctrl_rw,
  input  logic                    ctrl_done,
  input  logic [31:0]             ctrl_result,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  input  logic                    rsp_ready,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic [24:0] addr;
    logic [1:0]  oplen;
    logic [31:0] wdata;
    logic        rw;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_q;
  logic [TW-1:0]          timer_q;
  logic                   ctrl_enable_q;
  logic [24:0]            ctrl_addr_q;
  logic [1:0]             ctrl_oplen_q;
  logic [31:0]            ctrl_wdata_q;
  logic                   ctrl_rw_q;
  logic                   rsp_valid_q;
  logic [31:0]            rsp_data_q;
  logic                   rsp_err_q;

  req_t                   wr_req, head;
  logic                   fifo_full, push, pop;
  logic [$clog2(DEPTH):0] fifo_cnt;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign req_ready = !fifo_full && !rst;
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && (fifo_cnt != '0);
  assign wr_req    = '{addr: req_addr, oplen: req_oplen, wdata: req_wdata, rw: req_rw};

  sdram_req_queue_fifo #(.W($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_dat (wr_req),
    .rd_dat (head),
    .count  (fifo_cnt),
    .full   (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      ctrl_enable_q <= 1'b0;
      ctrl_addr_q   <= '0;
      ctrl_oplen_q  <= '0;
      ctrl_wdata_q  <= '0;
      ctrl_rw_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      ctrl_enable_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fifo_cnt != '0) begin
            ctrl_addr_q   <= head.addr;
            ctrl_oplen_q  <= head.oplen;
            ctrl_wdata_q  <= head.wdata;
            ctrl_rw_q     <= head.rw;
            ctrl_enable_q <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Completion takes priority over a timeout landing on the same edge.
          if (ctrl_done) begin
            rsp_data_q  <= ctrl_rw_q ? 32'd0 : ctrl_result;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (timer_q == TMAX) begin
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctrl_enable = ctrl_enable_q;
  assign ctrl_addr   = ctrl_addr_q;
  assign ctrl_oplen  = ctrl_oplen_q;
  assign ctrl_wdata  = ctrl_wdata_q;
  assign ctrl_rw     = ctrl_rw_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign count       = fifo_cnt;
endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed bench for sdram_req_queue: inputs driven and outputs sampled 1ns after each falling edge.
module tb_sdram_req_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [24:0] req_addr;
  logic [1:0]  req_oplen;
  logic [31:0] req_wdata;
  logic        req_rw;
  logic        ctrl_enable;
  logic [24:0] ctrl_addr;
  logic [1:0]  ctrl_oplen;
  logic [31:0] ctrl_wdata;
  logic        ctrl_rw;
  logic        ctrl_done;
  logic [31:0] ctrl_result;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;

  sdram_req_queue #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_oplen(req_oplen), .req_wdata(req_wdata), .req_rw(req_rw),
    .ctrl_enable(ctrl_enable), .ctrl_addr(ctrl_addr), .ctrl_oplen(ctrl_oplen),
    .ctrl_wdata(ctrl_wdata), .ctrl_rw(ctrl_rw), .ctrl_done(ctrl_done),
    .ctrl_result(ctrl_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready), .count(count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ctrl_enable) en_cnt <= en_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; req_valid = 1'b0; ctrl_done = 1'b0; rsp_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    tick; tick;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
    checks++; if ({ctrl_enable, rsp_valid, rsp_err} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {ctrl_enable, rsp_valid, rsp_err}); end
    checks++; if ({ctrl_addr, ctrl_wdata, rsp_data} !== '0) begin errors++; $display("FAIL rst_data got %h/%h/%h exp 0", ctrl_addr, ctrl_wdata, rsp_data); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_single_read;
    int en0;
    en0 = en_cnt;
    req_valid = 1'b1; req_addr = 25'h00000C8; req_rw = 1'b0; req_oplen = 2'd1; req_wdata = 32'h0;
    tick;
    req_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rd_count_after_push got %0d exp 1", count); end
    checks++; if (ctrl_enable !== 1'b0) begin errors++; $display("FAIL rd_enable_early got %b exp 0", ctrl_enable); end
    tick;
    checks++; if (ctrl_enable !== 1'b1) begin errors++; $display("FAIL rd_enable got %b exp 1", ctrl_enable); end
    checks++; if (ctrl_addr !== 25'h00000C8 || ctrl_oplen !== 2'd1 || ctrl_rw !== 1'b0) begin errors++; $display("FAIL rd_ctrl got %h/%0d/%b exp 0c8/1/0", ctrl_addr, ctrl_oplen, ctrl_rw); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rd_count_after_pop got %0d exp 0", count); end
    tick;
    checks++; if (ctrl_enable !== 1'b0) begin errors++; $display("FAIL rd_enable_width got %b exp 0", ctrl_enable); end
    repeat (4) tick;
    ctrl_done = 1'b1; ctrl_result = 32'h000000BE;
    tick;
    ctrl_done = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h000000BE || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp got %b/%h/%b exp 1/000000be/0", rsp_valid, rsp_data, rsp_err); end
    tick;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h000000BE) begin errors++; $display("FAIL rd_rsp_hold got %b/%h exp 1/000000be", rsp_valid, rsp_data); end
    checks++; if (en_cnt - en0 !== 1) begin errors++; $display("FAIL rd_enable_pulses got %0d exp 1", en_cnt - en0); end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_release got %b exp 0", rsp_valid); end
  endtask

  task automatic test_fill;
    int n;
    req_rw = 1'b0; req_wdata = 32'h0; req_oplen = 2'd0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr = 25'h100 + 25'(i);
      tick;
    end
    req_addr = 25'h105;
    checks++; if (count !== 3'd4 || req_ready !== 1'b0) begin errors++; $display("FAIL fill_full got %0d/%b exp 4/0", count, req_ready); end
    checks++; if (ctrl_addr !== 25'h100) begin errors++; $display("FAIL fill_inflight got %h exp 100", ctrl_addr); end
    tick; tick;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_stall got %0d exp 4", count); end
    ctrl_done = 1'b1; ctrl_result = 32'h11;
    tick;
    ctrl_done = 1'b0;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_no_pop_in_resp got %0d exp 4", count); end
    tick;
    checks++; if (count !== 3'd3 || ctrl_addr !== 25'h101) begin errors++; $display("FAIL fill_no_bypass got %0d/%h exp 3/101", count, ctrl_addr); end
    tick;
    req_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_sixth_push got %0d exp 4", count); end
    for (int k = 1; k <= 5; k++) begin
      ctrl_done = 1'b1; ctrl_result = 32'h200 + k;
      tick;
      ctrl_done = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h200 + k) begin errors++; $display("FAIL fill_rsp%0d got %b/%h exp 1/%h", k, rsp_valid, rsp_data, 32'h200 + k); end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      if (k < 5) begin
        n = 0;
        while (!ctrl_enable && n < 10) begin tick; n++; end
        checks++; if (ctrl_enable !== 1'b1 || ctrl_addr !== 25'h101 + 25'(k)) begin errors++; $display("FAIL fill_order%0d got %b/%h exp 1/%h", k, ctrl_enable, ctrl_addr, 25'h101 + 25'(k)); end
        tick;
      end
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_drained got %0d exp 0", count); end
  endtask

  task automatic test_ordering;
    int n;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 25'h10; req_rw = 1'b1; req_wdata = 32'hDEADBEEF; req_oplen = 2'd2;
    tick;
    req_rw = 1'b0; req_wdata = 32'h0; req_oplen = 2'd0;
    tick;
    req_valid = 1'b0;
    n = 0;
    while (!ctrl_enable && n < 10) begin tick; n++; end
    checks++; if (ctrl_enable !== 1'b1 || ctrl_rw !== 1'b1 || ctrl_wdata !== 32'hDEADBEEF || ctrl_addr !== 25'h10 || ctrl_oplen !== 2'd2) begin errors++; $display("FAIL ord_first got %b/%b/%h/%h exp 1/1/deadbeef/10", ctrl_enable, ctrl_rw, ctrl_wdata, ctrl_addr); end
    tick;
    ctrl_done = 1'b1; ctrl_result = 32'h12345678;
    tick;
    ctrl_done = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL ord_write_rsp got %b/%h/%b exp 1/0/0", rsp_valid, rsp_data, rsp_err); end
    n = 0;
    while (!ctrl_enable && n < 10) begin tick; n++; end
    checks++; if (ctrl_enable !== 1'b1 || ctrl_rw !== 1'b0 || ctrl_addr !== 25'h10) begin errors++; $display("FAIL ord_second got %b/%b/%h exp 1/0/10", ctrl_enable, ctrl_rw, ctrl_addr); end
    tick;
    ctrl_done = 1'b1; ctrl_result = 32'hCAFEF00D;
    tick;
    ctrl_done = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFEF00D) begin errors++; $display("FAIL ord_read_rsp got %b/%h exp 1/cafef00d", rsp_valid, rsp_data); end
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int cyc;
    req_valid = 1'b1; req_addr = 25'h55; req_rw = 1'b0;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin tick; cyc++; end
    checks++; if (cyc !== 64) begin errors++; $display("FAIL to_latency got %0d exp 64", cyc); end
    checks++; if (rsp_err !== 1'b1 || rsp_data !== 32'h0) begin errors++; $display("FAIL to_rsp got %b/%h exp 1/0", rsp_err, rsp_data); end
    ctrl_done = 1'b1; ctrl_result = 32'hFFFF0000;
    tick;
    ctrl_done = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin errors++; $display("FAIL to_done_ignored got %b/%b/%h exp 1/1/0", rsp_valid, rsp_err, rsp_data); end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic test_collision;
    req_valid = 1'b1; req_addr = 25'h77; req_rw = 1'b0;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    repeat (63) tick;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL col_early got %b exp 0", rsp_valid); end
    ctrl_done = 1'b1; ctrl_result = 32'h0000A5A5;
    tick;
    ctrl_done = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h0000A5A5) begin errors++; $display("FAIL col_rsp got %b/%b/%h exp 1/0/0000a5a5", rsp_valid, rsp_err, rsp_data); end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    int stale;
    int en0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 25'h1A0 + 25'(i); req_rw = 1'b0;
      tick;
    end
    req_valid = 1'b0;
    tick;
    checks++; if (count !== 3'd2 || ctrl_addr !== 25'h1A0) begin errors++; $display("FAIL ar_setup got %0d/%h exp 2/1a0", count, ctrl_addr); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || req_ready !== 1'b0) begin errors++; $display("FAIL ar_queue got %0d/%b exp 0/0", count, req_ready); end
    checks++; if ({ctrl_enable, rsp_valid, rsp_err} !== 3'b000 || ctrl_addr !== 25'h0 || rsp_data !== 32'h0) begin errors++; $display("FAIL ar_outputs got %b/%h/%h exp 000/0/0", {ctrl_enable, rsp_valid, rsp_err}, ctrl_addr, rsp_data); end
    tick; tick;
    rst = 1'b0;
    rsp_ready = 1'b1;
    en0 = en_cnt;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (rsp_valid || ctrl_enable) stale++;
    end
    rsp_ready = 1'b0;
    checks++; if (stale !== 0 || en_cnt != en0) begin errors++; $display("FAIL ar_stale got %0d exp 0", stale); end
    req_valid = 1'b1; req_addr = 25'h321; req_rw = 1'b1; req_wdata = 32'h5;
    tick;
    req_valid = 1'b0;
    checks++; if (count !== 3'd1 || ctrl_enable !== 1'b0) begin errors++; $display("FAIL ar_first_push got %0d/%b exp 1/0", count, ctrl_enable); end
    tick;
    checks++; if (ctrl_enable !== 1'b1 || ctrl_addr !== 25'h321 || ctrl_rw !== 1'b1) begin errors++; $display("FAIL ar_first_issue got %b/%h/%b exp 1/321/1", ctrl_enable, ctrl_addr, ctrl_rw); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_oplen = '0; req_wdata = '0; req_rw = 1'b0;
    ctrl_done = 1'b0; ctrl_result = '0; rsp_ready = 1'b0;
    test_reset;
    test_single_read;
    test_fill;
    test_ordering;
    test_timeout;
    test_collision;
    test_async_reset;
    apply_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
